// File: rtl/tx_fifo_arb_if.sv
// Shared-TX-FIFO arbiter bus bundle.
// The bundle carries the producer side (request, length, byte strobe/data, grant)
// and the uart TX FIFO write port (wen/wdata out, full/usedw back).
// The slave modport is the arbiter view; the master modport is the surrounding logic.
interface tx_fifo_arb_if #(
    parameter int N_REQ = 2,
    parameter int LEN_W = 12
) ();
    logic [N_REQ-1:0]       req;
    logic [N_REQ*LEN_W-1:0] req_len;
    logic [N_REQ-1:0]       src_wen;
    logic [N_REQ*8-1:0]     src_wdata;
    logic [N_REQ-1:0]       gnt;
    logic                   tx_fifo_wen;
    logic [7:0]             tx_fifo_wdata;
    logic                   tx_fifo_full;
    logic [11:0]            tx_fifo_usedw;

    modport master (
        output req, req_len, src_wen, src_wdata, tx_fifo_full, tx_fifo_usedw,
        input  gnt, tx_fifo_wen, tx_fifo_wdata
    );

    modport slave (
        input  req, req_len, src_wen, src_wdata, tx_fifo_full, tx_fifo_usedw,
        output gnt, tx_fifo_wen, tx_fifo_wdata
    );
endinterface

// File: rtl/tx_fifo_arb.sv
// tx_fifo_arb: frame-atomic round-robin arbiter in front of one uart TX FIFO.
// A producer is granted only when its whole frame fits in the free FIFO space;
// its bytes are forwarded with one cycle of latency, counted, and the grant is
// released after the last byte. A one-cycle release state lets usedw catch up.
// Optional feature macro: TXARB_WDOG_EN adds a stall watchdog in GRANT that
// aborts a frame whose producer stops sending for WDOG_CYC cycles.
module tx_fifo_arb #(
    parameter int N_REQ      = 2,
    parameter int FIFO_DEPTH = 4096,
    parameter int LEN_W      = 12,
    parameter int WDOG_CYC   = 65535
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          ena_i,
    tx_fifo_arb_if.slave  bus,
    output logic          busy_o,
    output logic          err_ovf_o,
    output logic          err_timeout_o
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int WD_W  = (WDOG_CYC > 2) ? $clog2(WDOG_CYC) : 1;

    // Reject configurations the arbiter cannot support at elaboration time.
    if ((N_REQ < 1) || (N_REQ > 8) || (WDOG_CYC < 2)) begin : g_bad_cfg
        $error("tx_fifo_arb: unsupported N_REQ or WDOG_CYC");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_REL   = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   winner_q, winner_d;
    logic [IDX_W-1:0]   last_q, last_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   cnt_q, cnt_d;
    logic [N_REQ-1:0]   gnt_q, gnt_d;
    logic               wen_q, wen_d;
    logic [7:0]         wdata_q, wdata_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, busy_d;
    logic               to_q, to_d;
`ifdef TXARB_WDOG_EN
    logic [WD_W-1:0]    stall_q, stall_d;
`endif

    logic [LEN_W-1:0]   len_a [N_REQ];
    logic [N_REQ-1:0]   elig_s;
    logic               found_s;
    logic [IDX_W-1:0]   pick_s;
    logic [IDX_W-1:0]   idx_s;
    int                 free_s;

    // Eligibility per source and round-robin pick starting after the last winner.
    always_comb begin
        free_s  = FIFO_DEPTH - 1 - int'(bus.tx_fifo_usedw);
        elig_s  = {N_REQ{1'b0}};
        found_s = 1'b0;
        pick_s  = {IDX_W{1'b0}};
        idx_s   = {IDX_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            len_a[i]  = bus.req_len[i*LEN_W +: LEN_W];
            elig_s[i] = bus.req[i] && (len_a[i] != {LEN_W{1'b0}}) && (int'(len_a[i]) <= free_s);
        end
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = IDX_W'((int'(last_q) + 1 + k) % N_REQ);
            if (!found_s && elig_s[idx_s]) begin
                found_s = 1'b1;
                pick_s  = idx_s;
            end else begin
                found_s = found_s;
            end
        end
    end

    // Next-state and registered-output computation for the IDLE/GRANT/REL FSM.
    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        len_d    = len_q;
        cnt_d    = cnt_q;
        gnt_d    = {N_REQ{1'b0}};
        wen_d    = 1'b0;
        wdata_d  = wdata_q;
        ovf_d    = 1'b0;
        to_d     = 1'b0;
`ifdef TXARB_WDOG_EN
        stall_d  = stall_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (ena_i && found_s) begin
                    state_d  = S_GRANT;
                    winner_d = pick_s;
                    last_d   = pick_s;
                    len_d    = len_a[pick_s];
                    cnt_d    = {LEN_W{1'b0}};
`ifdef TXARB_WDOG_EN
                    stall_d  = {WD_W{1'b0}};
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_GRANT: begin
                if (bus.src_wen[winner_q]) begin
                    // A byte that hits a full FIFO is dropped but still counts,
                    // so the frame boundary stays aligned with the producer.
                    cnt_d = cnt_q + {{(LEN_W-1){1'b0}}, 1'b1};
                    if (bus.tx_fifo_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        wen_d   = 1'b1;
                        wdata_d = bus.src_wdata[{winner_q, 3'b000} +: 8];
                    end
                    if (cnt_q == (len_q - {{(LEN_W-1){1'b0}}, 1'b1})) begin
                        state_d = S_REL;
                    end else begin
                        state_d = S_GRANT;
                    end
`ifdef TXARB_WDOG_EN
                    stall_d = {WD_W{1'b0}};
                end else if (stall_q == WD_W'(WDOG_CYC - 1)) begin
                    to_d    = 1'b1;
                    state_d = S_REL;
                end else begin
                    stall_d = stall_q + {{(WD_W-1){1'b0}}, 1'b1};
                    state_d = S_GRANT;
                end
`else
                end else begin
                    state_d = S_GRANT;
                end
`endif
            end
            S_REL: begin
                cnt_d   = {LEN_W{1'b0}};
                state_d = S_IDLE;
            end
            default: begin
                cnt_d   = {LEN_W{1'b0}};
                state_d = S_IDLE;
            end
        endcase
        if (state_d == S_GRANT) begin
            gnt_d[winner_d] = 1'b1;
        end else begin
            gnt_d = {N_REQ{1'b0}};
        end
        busy_d = (state_d != S_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= S_IDLE;
            winner_q <= {IDX_W{1'b0}};
            last_q   <= IDX_W'(N_REQ - 1);
            len_q    <= {LEN_W{1'b0}};
            cnt_q    <= {LEN_W{1'b0}};
            gnt_q    <= {N_REQ{1'b0}};
            wen_q    <= 1'b0;
            wdata_q  <= 8'h00;
            ovf_q    <= 1'b0;
            busy_q   <= 1'b0;
            to_q     <= 1'b0;
`ifdef TXARB_WDOG_EN
            stall_q  <= {WD_W{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            len_q    <= len_d;
            cnt_q    <= cnt_d;
            gnt_q    <= gnt_d;
            wen_q    <= wen_d;
            wdata_q  <= wdata_d;
            ovf_q    <= ovf_d;
            busy_q   <= busy_d;
            to_q     <= to_d;
`ifdef TXARB_WDOG_EN
            stall_q  <= stall_d;
`endif
        end
    end

    assign bus.gnt           = gnt_q;
    assign bus.tx_fifo_wen   = wen_q;
    assign bus.tx_fifo_wdata = wdata_q;
    assign busy_o            = busy_q;
    assign err_ovf_o         = ovf_q;
    assign err_timeout_o     = to_q;
endmodule

// File: tb/tb_tx_fifo_arb.sv
// Directed testbench for tx_fifo_arb with hand-computed expectations.
// Inputs change 1 time unit after the rising edge; outputs are sampled there too.
module tb_tx_fifo_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ena = 1'b0;
    logic busy, err_ovf, err_to;
    int   total = 0;
    int   bad   = 0;

    tx_fifo_arb_if #(.N_REQ(2), .LEN_W(12)) bus ();

    tx_fifo_arb #(
        .N_REQ(2), .FIFO_DEPTH(4096), .LEN_W(12), .WDOG_CYC(16)
    ) dut (
        .clk_i(clk), .rst_i(rst), .ena_i(ena), .bus(bus.slave),
        .busy_o(busy), .err_ovf_o(err_ovf), .err_timeout_o(err_to)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one byte from source src for exactly one edge.
    task automatic feed(input int src, input logic [7:0] data);
        bus.src_wen = 2'b00;
        bus.src_wen[src] = 1'b1;
        bus.src_wdata[src*8 +: 8] = data;
        step();
        bus.src_wen = 2'b00;
    endtask

    // Stream n bytes base, base+1, ... from src, checking each forwarded byte.
    task automatic run_frame(input int src, input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            feed(src, base + 8'(i));
            chk("wen", 32'(bus.tx_fifo_wen), 32'd1);
            chk("wdata", 32'(bus.tx_fifo_wdata), 32'(base + 8'(i)));
        end
        chk("gnt_fall", 32'(bus.gnt), 32'd0);
        chk("busy_rel", 32'(busy), 32'd1);
    endtask

    initial begin
        bus.req = 2'b00;
        bus.req_len = 24'h000000;
        bus.src_wen = 2'b00;
        bus.src_wdata = 16'h0000;
        bus.tx_fifo_full = 1'b0;
        bus.tx_fifo_usedw = 12'd0;
        step();
        step();
        chk("rst_gnt", 32'(bus.gnt), 32'd0);
        chk("rst_wen", 32'(bus.tx_fifo_wen), 32'd0);
        chk("rst_wdata", 32'(bus.tx_fifo_wdata), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovf", 32'(err_ovf), 32'd0);
        chk("rst_to", 32'(err_to), 32'd0);
        rst = 1'b0;

        // ena low: no grant even with eligible requests
        bus.req = 2'b11;
        bus.req_len = {12'd4, 12'd4};
        step();
        step();
        chk("ena_low_gnt", 32'(bus.gnt), 32'd0);

        // Both eligible: source 0 first, 4 bytes, then source 1 after REL
        ena = 1'b1;
        step();
        chk("first_gnt", 32'(bus.gnt), 32'd1);
        chk("busy_grant", 32'(busy), 32'd1);
        run_frame(0, 4, 8'h10);
        bus.req = 2'b10;
        step();
        chk("rel_gnt", 32'(bus.gnt), 32'd0);
        chk("rel_busy", 32'(busy), 32'd0);
        chk("rel_wen", 32'(bus.tx_fifo_wen), 32'd0);
        step();
        chk("rr_gnt", 32'(bus.gnt), 32'd2);
        feed(0, 8'hEE);
        chk("nongrant_wen", 32'(bus.tx_fifo_wen), 32'd0);
        run_frame(1, 4, 8'h20);
        bus.req = 2'b00;
        step();
        step();
        chk("idle_busy", 32'(busy), 32'd0);

        // Space limited: usedw=4090 leaves 5 bytes, only source 1 (len 3) fits
        bus.tx_fifo_usedw = 12'd4090;
        bus.req_len = {12'd3, 12'd8};
        bus.req = 2'b11;
        step();
        chk("space_gnt", 32'(bus.gnt), 32'd2);
        run_frame(1, 3, 8'h30);
        bus.req = 2'b01;
        step();
        step();
        step();
        chk("wait_4090", 32'(bus.gnt), 32'd0);
        bus.tx_fifo_usedw = 12'd4088;
        step();
        step();
        chk("wait_4088", 32'(bus.gnt), 32'd0);
        bus.tx_fifo_usedw = 12'd4087;
        step();
        chk("fit_4087", 32'(bus.gnt), 32'd1);

        // Source 0 frame of 8 with a foreign strobe and an overflowed byte
        feed(0, 8'hA5);
        chk("a5_wen", 32'(bus.tx_fifo_wen), 32'd1);
        chk("a5_data", 32'(bus.tx_fifo_wdata), 32'hA5);
        feed(1, 8'h99);
        chk("src1_ign", 32'(bus.tx_fifo_wen), 32'd0);
        feed(0, 8'h5A);
        chk("5a_wen", 32'(bus.tx_fifo_wen), 32'd1);
        chk("5a_data", 32'(bus.tx_fifo_wdata), 32'h5A);
        bus.tx_fifo_full = 1'b1;
        feed(0, 8'h77);
        chk("ovf_pulse", 32'(err_ovf), 32'd1);
        chk("ovf_wen", 32'(bus.tx_fifo_wen), 32'd0);
        bus.tx_fifo_full = 1'b0;
        step();
        chk("ovf_clr", 32'(err_ovf), 32'd0);
        chk("ovf_gnt", 32'(bus.gnt), 32'd1);
        run_frame(0, 5, 8'h40);
        bus.req = 2'b00;
        feed(0, 8'hFF);
        chk("extra_wen", 32'(bus.tx_fifo_wen), 32'd0);
        step();
        chk("end_busy", 32'(busy), 32'd0);

        // Reset in the middle of a 6-byte frame
        bus.tx_fifo_usedw = 12'd0;
        bus.req_len = {12'd6, 12'd6};
        bus.req = 2'b01;
        step();
        chk("mid_gnt", 32'(bus.gnt), 32'd1);
        feed(0, 8'h01);
        feed(0, 8'h02);
        rst = 1'b1;
        step();
        chk("mrst_gnt", 32'(bus.gnt), 32'd0);
        chk("mrst_wen", 32'(bus.tx_fifo_wen), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        bus.req = 2'b11;
        step();
        chk("restart_src0", 32'(bus.gnt), 32'd1);

`ifdef TXARB_WDOG_EN
        // Granted source stays silent: abort after 16 cycles in GRANT
        for (int i = 0; i < 15; i++) step();
        chk("wd_pre_gnt", 32'(bus.gnt), 32'd1);
        chk("wd_pre_to", 32'(err_to), 32'd0);
        step();
        chk("wd_to", 32'(err_to), 32'd1);
        chk("wd_gnt", 32'(bus.gnt), 32'd0);
        bus.req = 2'b10;
        step();
        chk("wd_to_clr", 32'(err_to), 32'd0);
        step();
        chk("wd_next", 32'(bus.gnt), 32'd2);
`else
        // Without the watchdog a silent source keeps the grant
        for (int i = 0; i < 20; i++) step();
        chk("nowd_gnt", 32'(bus.gnt), 32'd1);
        chk("nowd_to", 32'(err_to), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
